// File: rtl/keypad_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keypad_scanner_if                                               |
// | Brief    : Keypad pins, key handshake and entry-value bundle.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface keypad_scanner_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack;
  logic        clear;
  logic [31:0] value;
  logic        overrun;

  modport slave (
    input  row_in, key_ack, clear,
    output col_out, key_valid, key_code, value, overrun
  );

  modport master (
    output row_in, key_ack, clear,
    input  col_out, key_valid, key_code, value, overrun
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keypad_scanner                                                  |
// | Brief    : 4x4 hex keypad column scanner with debounce, valid/ack key      |
// |            reporting and a 32-bit shifted digit-entry register.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic            clk,
  input  logic            reset,
  keypad_scanner_if.slave bus
);

  localparam int c_DIV_W = $clog2(SCAN_DIV);
  localparam int c_DEB_W = $clog2(DEBOUNCE_CNT);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [3:0]          r_row_meta;
  logic [3:0]          r_rows_s;
  logic [1:0]          r_col;
  logic [3:0]          r_col_out;
  logic [1:0]          r_row;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic [c_DEB_W-1:0]  r_deb_cnt;
  logic                r_key_valid;
  logic [3:0]          r_key_code;
  logic [31:0]         r_value;
  logic                r_overrun;

  logic [1:0]          w_low_row;
  logic [3:0]          w_code;
  logic                w_event;
  logic                w_accept;

  // Lowest-index low row wins when several keys in the column are down.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_rows_s[2]) w_low_row = 2'd2;
    if (!r_rows_s[1]) w_low_row = 2'd1;
    if (!r_rows_s[0]) w_low_row = 2'd0;
  end

  always_comb begin
    w_code = 4'h0;
    case ({r_row, r_col})
      4'h0: w_code = 4'h1;  4'h1: w_code = 4'h2;  4'h2: w_code = 4'h3;  4'h3: w_code = 4'hA;
      4'h4: w_code = 4'h4;  4'h5: w_code = 4'h5;  4'h6: w_code = 4'h6;  4'h7: w_code = 4'hB;
      4'h8: w_code = 4'h7;  4'h9: w_code = 4'h8;  4'hA: w_code = 4'h9;  4'hB: w_code = 4'hC;
      4'hC: w_code = 4'hE;  4'hD: w_code = 4'h0;  4'hE: w_code = 4'hF;  4'hF: w_code = 4'hD;
      default: w_code = 4'h0;
    endcase
  end

  assign w_event  = (r_state == S_PRESSED);
  assign w_accept = w_event && (!r_key_valid || bus.key_ack);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_SCAN;
      r_row_meta  <= 4'hF;
      r_rows_s    <= 4'hF;
      r_col       <= 2'd0;
      r_col_out   <= 4'b1110;
      r_row       <= 2'd0;
      r_div_cnt   <= '0;
      r_deb_cnt   <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_value     <= 32'h0;
      r_overrun   <= 1'b0;
    end else begin
      r_row_meta <= bus.row_in;
      r_rows_s   <= r_row_meta;

      case (r_state)
        S_SCAN: begin
          if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            if (!(&r_rows_s)) begin
              r_row     <= w_low_row;
              r_deb_cnt <= '0;
              r_state   <= S_DEBOUNCE;
            end else begin
              r_col     <= r_col + 2'd1;
              r_col_out <= {r_col_out[2:0], r_col_out[3]};
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (!r_rows_s[r_row]) begin
            if (r_deb_cnt == c_DEB_LAST) r_state   <= S_PRESSED;
            else                         r_deb_cnt <= r_deb_cnt + 1'b1;
          end else begin
            r_state   <= S_SCAN;
            r_col     <= r_col + 2'd1;
            r_col_out <= {r_col_out[2:0], r_col_out[3]};
          end
        end
        S_PRESSED: begin
          r_deb_cnt <= '0;
          r_state   <= S_RELEASE;
        end
        S_RELEASE: begin
          // Release needs every row high, so a second key held in the column also blocks rescan.
          if (&r_rows_s) begin
            if (r_deb_cnt == c_DEB_LAST) begin
              r_state   <= S_SCAN;
              r_col     <= r_col + 2'd1;
              r_col_out <= {r_col_out[2:0], r_col_out[3]};
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end else begin
            r_deb_cnt <= '0;
          end
        end
        default: r_state <= S_SCAN;
      endcase

      if (w_accept) begin
        r_key_code  <= w_code;
        r_key_valid <= 1'b1;
      end else if (bus.key_ack && r_key_valid) begin
        r_key_valid <= 1'b0;
      end

      if (bus.clear)     r_value <= 32'h0;
      else if (w_accept) r_value <= {r_value[27:0], w_code};

      if (bus.clear)                 r_overrun <= 1'b0;
      else if (w_event && !w_accept) r_overrun <= 1'b1;
    end
  end

  assign bus.col_out   = r_col_out;
  assign bus.key_valid = r_key_valid;
  assign bus.key_code  = r_key_code;
  assign bus.value     = r_value;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire
